change_dispenser: RTL and testbench

- Output-side partner of the vending_machine FSM. It consumes the one-cycle vend/out1/out2/out22 pulses and queues them.
- It then drives the product motor and the 1- and 2-unit coin hoppers, one actuation at a time, using a request/ack handshake with a timeout.
- It tracks hopper coin inventory and reports busy, empty and fault status back to the front panel.

---
 rtl/dispenser_pkg.sv | 11 +
 rtl/disp_handshake.sv | 67 ++++++
 rtl/change_dispenser.sv | 151 +++++++++++++++
 tb/tb_change_dispenser.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dispenser_pkg.sv
// Shared types and constants for the change dispenser: FSM states, actuator select, coin values.
package dispenser_pkg;

  typedef enum logic [1:0] {IDLE, ACT, GAPW, FAULT} state_t;

  typedef enum logic [1:0] {SEL_MOTOR, SEL_HOP1, SEL_HOP2} sel_t;

  localparam int COIN1_VAL = 1;
  localparam int COIN2_VAL = 2;

endpackage

// File: rtl/disp_handshake.sv
// Request/acknowledge engine: holds one actuator request until its ack arrives or TIMEOUT cycles elapse.
module disp_handshake
  import dispenser_pkg::*;
#(
  parameter int TIMEOUT = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  sel_t which_ack,
  input  logic motor_ack,
  input  logic hop1_ack,
  input  logic hop2_ack,
  output logic motor_req,
  output logic hop1_req,
  output logic hop2_req,
  output logic done,
  output logic timeout
);

  localparam int TW = $clog2(TIMEOUT + 1);

  logic          active;
  sel_t          sel;
  logic [TW-1:0] timer;
  logic          ack_hit;

  // Only the ack belonging to the actuator being driven counts.
  always_comb begin
    ack_hit = 1'b0;
    case (sel)
      SEL_MOTOR: ack_hit = motor_ack;
      SEL_HOP1:  ack_hit = hop1_ack;
      SEL_HOP2:  ack_hit = hop2_ack;
      default:   ack_hit = 1'b0;
    endcase
  end

  assign done    = active && ack_hit;
  assign timeout = active && !ack_hit && (timer == TW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      active    <= 1'b0;
      sel       <= SEL_MOTOR;
      timer     <= '0;
      motor_req <= 1'b0;
      hop1_req  <= 1'b0;
      hop2_req  <= 1'b0;
    end else if (start) begin
      active    <= 1'b1;
      sel       <= which_ack;
      timer     <= '0;
      motor_req <= (which_ack == SEL_MOTOR);
      hop1_req  <= (which_ack == SEL_HOP1);
      hop2_req  <= (which_ack == SEL_HOP2);
    end else if (done || timeout) begin
      active    <= 1'b0;
      motor_req <= 1'b0;
      hop1_req  <= 1'b0;
      hop2_req  <= 1'b0;
    end else if (active) begin
      timer <= timer + 1'b1;
    end
  end

endmodule

// File: rtl/change_dispenser.sv
// Queues vend/coin-return pulses and drives motor and hoppers one actuation at a time.
// Optional DISP_STATS_EN adds cumulative total_paid / total_vends counters.
module change_dispenser
  import dispenser_pkg::*;
#(
  parameter int PEND_W   = 4,
  parameter int INV_W    = 8,
  parameter int INV_INIT = 20,
  parameter int TIMEOUT  = 1000,
  parameter int GAP      = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             vend,
  input  logic             out1,
  input  logic             out2,
  input  logic             out22,
  input  logic             restock,
  output logic             motor_req,
  input  logic             motor_ack,
  output logic             hop1_req,
  input  logic             hop1_ack,
  output logic             hop2_req,
  input  logic             hop2_ack,
  output logic             busy,
  output logic             empty1,
  output logic             empty2,
  output logic             fault,
  output logic [INV_W-1:0] inv1,
  output logic [INV_W-1:0] inv2
`ifdef DISP_STATS_EN
  ,
  output logic [15:0]      total_paid,
  output logic [15:0]      total_vends
`endif
);

  localparam int GW = $clog2(GAP + 1);

  state_t          state;
  logic [GW-1:0]   gcnt;
  logic [PEND_W-1:0] pv, p1, p2;
  logic [PEND_W:0] nv, n1, n2;
  sel_t            pick;
  logic            have_work, empty_hit, start, sel_fault;
  logic            dec_v, dec_1, dec_2, ovf;
  logic            hs_done, hs_timeout;

  // Returns {overflow, next count}; the count saturates at all-ones.
  function automatic logic [PEND_W:0] pend_next(input logic [PEND_W-1:0] cur,
                                                input logic [1:0] inc, input logic dec);
    logic [PEND_W+1:0] sum;
    sum = (PEND_W+2)'(cur) + (PEND_W+2)'(inc) - (PEND_W+2)'(dec);
    if (sum[PEND_W+1:PEND_W] != 2'b00) pend_next = {1'b1, {PEND_W{1'b1}}};
    else                               pend_next = {1'b0, sum[PEND_W-1:0]};
  endfunction

  always_comb begin
    pick      = SEL_MOTOR;
    have_work = 1'b1;
    if (pv != '0)      pick = SEL_MOTOR;
    else if (p2 != '0) pick = SEL_HOP2;
    else if (p1 != '0) pick = SEL_HOP1;
    else               have_work = 1'b0;
    empty_hit = have_work && (((pick == SEL_HOP2) && (inv2 == '0)) ||
                              ((pick == SEL_HOP1) && (inv1 == '0)));
    sel_fault = (state == IDLE) && empty_hit;
    start     = (state == IDLE) && have_work && !empty_hit;
    dec_v     = start && (pick == SEL_MOTOR);
    dec_1     = start && (pick == SEL_HOP1);
    dec_2     = start && (pick == SEL_HOP2);
  end

  // out22 carries weight 2 and out2 weight 1, so {out22, out2} is the p2 increment.
  assign nv  = pend_next(pv, {1'b0, vend}, dec_v);
  assign n1  = pend_next(p1, {1'b0, out1}, dec_1);
  assign n2  = pend_next(p2, {out22, out2}, dec_2);
  assign ovf = nv[PEND_W] | n1[PEND_W] | n2[PEND_W];

  disp_handshake #(.TIMEOUT(TIMEOUT)) u_hs (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .which_ack (pick),
    .motor_ack (motor_ack),
    .hop1_ack  (hop1_ack),
    .hop2_ack  (hop2_ack),
    .motor_req (motor_req),
    .hop1_req  (hop1_req),
    .hop2_req  (hop2_req),
    .done      (hs_done),
    .timeout   (hs_timeout)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      gcnt  <= '0;
      pv    <= '0;
      p1    <= '0;
      p2    <= '0;
      inv1  <= INV_W'(INV_INIT);
      inv2  <= INV_W'(INV_INIT);
      fault <= 1'b0;
    end else begin
      pv <= nv[PEND_W-1:0];
      p1 <= n1[PEND_W-1:0];
      p2 <= n2[PEND_W-1:0];
      case (state)
        IDLE:  if (sel_fault) state <= FAULT;
               else if (start) state <= ACT;
        ACT:   if (hs_done) begin
                 state <= GAPW;
                 gcnt  <= '0;
               end else if (hs_timeout) state <= FAULT;
        GAPW:  if (gcnt == GW'(GAP - 1)) state <= IDLE;
               else gcnt <= gcnt + 1'b1;
        FAULT: if (restock) state <= IDLE;
        default: state <= IDLE;
      endcase
      // A new error in the same cycle as restock keeps the flag set.
      fault <= (fault && !restock) || sel_fault || hs_timeout || ovf;
      if (restock) begin
        inv1 <= INV_W'(INV_INIT);
        inv2 <= INV_W'(INV_INIT);
      end else if (hs_done && hop1_req) begin
        inv1 <= inv1 - 1'b1;
      end else if (hs_done && hop2_req) begin
        inv2 <= inv2 - 1'b1;
      end
    end
  end

  assign busy   = (state != IDLE) || (pv != '0) || (p1 != '0) || (p2 != '0);
  assign empty1 = (inv1 == '0);
  assign empty2 = (inv2 == '0);

`ifdef DISP_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      total_paid  <= '0;
      total_vends <= '0;
    end else if (hs_done) begin
      if (motor_req) total_vends <= total_vends + 16'd1;
      if (hop1_req)  total_paid  <= total_paid + 16'(COIN1_VAL);
      if (hop2_req)  total_paid  <= total_paid + 16'(COIN2_VAL);
    end
  end
`endif

endmodule

// File: tb/tb_change_dispenser.sv
// Self-checking bench for change_dispenser: directed scenarios plus randomized traffic vs a count-level model.
`timescale 1ns/1ps
module tb_change_dispenser;

  localparam int INV_INIT = 20;
  localparam int TIMEOUT  = 1000;
  localparam int GAP      = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, vend, out1, out2, out22, restock, motor_ack, hop1_ack, hop2_ack;
  logic motor_req, hop1_req, hop2_req, busy, empty1, empty2, fault;
  logic [7:0] inv1, inv2;
`ifdef DISP_STATS_EN
  logic [15:0] total_paid, total_vends;
`endif

  int total = 0;
  int bad   = 0;
  int order_q[$];
  int min_gap;

  change_dispenser #(.PEND_W(4), .INV_W(8), .INV_INIT(INV_INIT), .TIMEOUT(TIMEOUT), .GAP(GAP)) dut (
    .clk(clk), .rst(rst), .vend(vend), .out1(out1), .out2(out2), .out22(out22), .restock(restock),
    .motor_req(motor_req), .motor_ack(motor_ack), .hop1_req(hop1_req), .hop1_ack(hop1_ack),
    .hop2_req(hop2_req), .hop2_ack(hop2_ack), .busy(busy), .empty1(empty1), .empty2(empty2),
    .fault(fault), .inv1(inv1), .inv2(inv2)
`ifdef DISP_STATS_EN
    , .total_paid(total_paid), .total_vends(total_vends)
`endif
  );

  function automatic logic [2:0] reqs();
    return {hop2_req, hop1_req, motor_req};
  endfunction

  task automatic clear_in();
    vend = 0; out1 = 0; out2 = 0; out22 = 0; restock = 0;
    motor_ack = 0; hop1_ack = 0; hop2_ack = 0;
  endtask

  task automatic drive_ack(input int k);
    case (k)
      0: motor_ack = 1;
      1: hop1_ack = 1;
      default: hop2_ack = 1;
    endcase
  endtask

  task automatic apply_reset();
    rst = 1; clear_in();
    @(negedge clk);
    rst = 0;
  endtask

  // Acks each request dly cycles after it rises; records order and shortest all-low run between requests.
  task automatic serve(input int ncyc, input int dly);
    logic [2:0] prev, cur;
    int gap, held;
    bit had;
    prev = 3'b000; gap = 0; held = 0; had = 0;
    for (int c = 0; c < ncyc; c++) begin
      cur = reqs();
      motor_ack = 0; hop1_ack = 0; hop2_ack = 0;
      for (int k = 0; k < 3; k++)
        if (cur[k] && !prev[k]) begin
          order_q.push_back(k);
          if (had && gap < min_gap) min_gap = gap;
          gap = 0; held = 0; had = 1;
        end
      if (cur == 3'b000) gap++;
      else begin
        if (held == dly)
          for (int k = 0; k < 3; k++) if (cur[k]) drive_ack(k);
        held++;
      end
      prev = cur;
      @(negedge clk);
    end
    motor_ack = 0; hop1_ack = 0; hop2_ack = 0;
  endtask

  task automatic test_reset();
    rst = 1; clear_in();
    @(negedge clk); @(negedge clk);
    total++; if (reqs() !== 3'b000) begin bad++; $display("FAIL reset_reqs got=%b want=000", reqs()); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if (fault !== 1'b0) begin bad++; $display("FAIL reset_fault got=%b want=0", fault); end
    total++; if (inv1 !== 8'd20) begin bad++; $display("FAIL reset_inv1 got=%0d want=20", inv1); end
    total++; if (inv2 !== 8'd20) begin bad++; $display("FAIL reset_inv2 got=%0d want=20", inv2); end
    total++; if ({empty1, empty2} !== 2'b00) begin bad++; $display("FAIL reset_empty got=%b want=00", {empty1, empty2}); end
    rst = 0;
    @(negedge clk);
  endtask

  task automatic test_single_out2();
    apply_reset();
    out2 = 1; @(negedge clk); out2 = 0;
    total++; if (hop2_req !== 1'b0) begin bad++; $display("FAIL s2_early got=%b want=0", hop2_req); end
    @(negedge clk);
    total++; if (hop2_req !== 1'b1) begin bad++; $display("FAIL s2_rise got=%b want=1", hop2_req); end
    repeat (5) @(negedge clk);
    total++; if (hop2_req !== 1'b1) begin bad++; $display("FAIL s2_hold got=%b want=1", hop2_req); end
    hop2_ack = 1; @(negedge clk); hop2_ack = 0;
    total++; if (hop2_req !== 1'b0) begin bad++; $display("FAIL s2_drop got=%b want=0", hop2_req); end
    total++; if (inv2 !== 8'd19) begin bad++; $display("FAIL s2_inv2 got=%0d want=19", inv2); end
    repeat (GAP - 1) @(negedge clk);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL s2_busy_gap got=%b want=1", busy); end
    @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL s2_busy_end got=%b want=0", busy); end
  endtask

  task automatic test_order();
    int exp_o[4];
    int got;
    exp_o = '{0, 2, 2, 1};
    apply_reset();
    vend = 1; out22 = 1; out1 = 1; @(negedge clk); clear_in();
    order_q.delete(); min_gap = 1000;
    serve(200, 1);
    total++; if (order_q.size() != 4) begin bad++; $display("FAIL ord_count got=%0d want=4", order_q.size()); end
    for (int i = 0; i < 4; i++) begin
      got = (i < order_q.size()) ? order_q[i] : -1;
      total++; if (got != exp_o[i]) begin bad++; $display("FAIL ord_item%0d got=%0d want=%0d", i, got, exp_o[i]); end
    end
    total++; if (min_gap < GAP) begin bad++; $display("FAIL ord_gap got=%0d want>=%0d", min_gap, GAP); end
    total++; if (inv1 !== 8'd19) begin bad++; $display("FAIL ord_inv1 got=%0d want=19", inv1); end
    total++; if (inv2 !== 8'd18) begin bad++; $display("FAIL ord_inv2 got=%0d want=18", inv2); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL ord_busy got=%b want=0", busy); end
`ifdef DISP_STATS_EN
    total++; if (total_vends !== 16'd1) begin bad++; $display("FAIL stats_vends got=%0d want=1", total_vends); end
    total++; if (total_paid !== 16'd5) begin bad++; $display("FAIL stats_paid got=%0d want=5", total_paid); end
`endif
  endtask

  task automatic test_timeout();
    int n, hi;
    bit seen;
    apply_reset();
    out1 = 1; @(negedge clk); out1 = 0;
    n = 0;
    while (!hop1_req && n < 10) begin @(negedge clk); n++; end
    total++; if (hop1_req !== 1'b1) begin bad++; $display("FAIL to_rise got=%b want=1", hop1_req); end
    hi = 0;
    while (hop1_req && hi < TIMEOUT + 50) begin hi++; @(negedge clk); end
    total++; if (hi != TIMEOUT) begin bad++; $display("FAIL to_len got=%0d want=%0d", hi, TIMEOUT); end
    total++; if (fault !== 1'b1) begin bad++; $display("FAIL to_fault got=%b want=1", fault); end
    total++; if (inv1 !== 8'd20) begin bad++; $display("FAIL to_inv1 got=%0d want=20", inv1); end
    out1 = 1; @(negedge clk); out1 = 0;
    seen = 0;
    repeat (10) begin if (reqs() != 3'b000) seen = 1; @(negedge clk); end
    total++; if (seen) begin bad++; $display("FAIL to_reqs_low got=1 want=0"); end
    total++; if (dut.p1 !== 4'd1) begin bad++; $display("FAIL to_p1 got=%0d want=1", dut.p1); end
    restock = 1; @(negedge clk); restock = 0;
    total++; if (fault !== 1'b0) begin bad++; $display("FAIL to_clear got=%b want=0", fault); end
    @(negedge clk);
    total++; if (hop1_req !== 1'b1) begin bad++; $display("FAIL to_resume got=%b want=1", hop1_req); end
    hop1_ack = 1; @(negedge clk); hop1_ack = 0;
    total++; if (inv1 !== 8'd19) begin bad++; $display("FAIL to_inv1_after got=%0d want=19", inv1); end
  endtask

  task automatic test_drain();
    int n;
    bit ok, seen;
    apply_reset();
    ok = 1;
    for (int i = 0; i < 20; i++) begin
      out1 = 1; @(negedge clk); out1 = 0;
      n = 0;
      while (!hop1_req && n < 10) begin @(negedge clk); n++; end
      if (!hop1_req) ok = 0;
      hop1_ack = 1; @(negedge clk); hop1_ack = 0;
      repeat (GAP + 1) @(negedge clk);
    end
    total++; if (!ok) begin bad++; $display("FAIL drain_serviced got=0 want=1"); end
    total++; if (inv1 !== 8'd0) begin bad++; $display("FAIL drain_inv1 got=%0d want=0", inv1); end
    total++; if (empty1 !== 1'b1) begin bad++; $display("FAIL drain_empty1 got=%b want=1", empty1); end
    total++; if (fault !== 1'b0) begin bad++; $display("FAIL drain_fault_pre got=%b want=0", fault); end
    out1 = 1; @(negedge clk); out1 = 0;
    seen = 0;
    repeat (20) begin if (hop1_req) seen = 1; @(negedge clk); end
    total++; if (seen) begin bad++; $display("FAIL drain_noreq got=1 want=0"); end
    total++; if (fault !== 1'b1) begin bad++; $display("FAIL drain_fault got=%b want=1", fault); end
    total++; if (dut.p1 !== 4'd1) begin bad++; $display("FAIL drain_p1 got=%0d want=1", dut.p1); end
    total++; if (empty2 !== 1'b0) begin bad++; $display("FAIL drain_empty2 got=%b want=0", empty2); end
  endtask

  task automatic test_overflow();
    int expv;
    apply_reset();
    for (int i = 0; i <= 16; i++) begin
      vend = 1; @(negedge clk);
      expv = (i == 0) ? 1 : ((i > 15) ? 15 : i);
      total++; if (dut.pv !== 4'(expv)) begin bad++; $display("FAIL ovf_pv%0d got=%0d want=%0d", i, dut.pv, expv); end
      total++; if (fault !== (i >= 16)) begin bad++; $display("FAIL ovf_fault%0d got=%b want=%0d", i, fault, i >= 16); end
    end
    vend = 0;
    total++; if (motor_req !== 1'b1) begin bad++; $display("FAIL ovf_motor got=%b want=1", motor_req); end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    out2 = 1; out22 = 1; @(negedge clk); out22 = 0; @(negedge clk); out2 = 0;
    total++; if (hop2_req !== 1'b1) begin bad++; $display("FAIL rm_req got=%b want=1", hop2_req); end
    total++; if (dut.p2 !== 4'd3) begin bad++; $display("FAIL rm_p2 got=%0d want=3", dut.p2); end
    rst = 1; @(negedge clk); rst = 0;
    total++; if (hop2_req !== 1'b0) begin bad++; $display("FAIL rm_drop got=%b want=0", hop2_req); end
    total++; if (dut.p2 !== 4'd0) begin bad++; $display("FAIL rm_p2_clr got=%0d want=0", dut.p2); end
    total++; if (inv2 !== 8'd20) begin bad++; $display("FAIL rm_inv2 got=%0d want=20", inv2); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rm_busy got=%b want=0", busy); end
  endtask

  // Model keeps pending counts per actuator and inventories; the next actuation must be the
  // highest-priority nonzero count (motor, then 2-unit, then 1-unit).
  task automatic test_random();
    int mp[3];
    int minv1, minv2, act, dly, nrise, e, c1, c2, r;
    logic [2:0] prev, cur;
    bit dv, d1, d2, d22, drs;
    apply_reset();
    mp = '{0, 0, 0}; minv1 = INV_INIT; minv2 = INV_INIT;
    act = -1; dly = -1; nrise = 0; prev = 3'b000;
    dv = 0; d1 = 0; d2 = 0; d22 = 0; drs = 0;
    for (int c = 0; c < 2300; c++) begin
      cur = reqs();
      motor_ack = 0; hop1_ack = 0; hop2_ack = 0;
      total++; if ((cur & (cur - 3'd1)) != 3'b000) begin bad++; $display("FAIL rnd_onehot got=%b want=onehot", cur); end
      for (int k = 0; k < 3; k++) begin
        if (cur[k] && !prev[k]) begin
          e = (mp[0] > 0) ? 0 : (mp[2] > 0) ? 2 : (mp[1] > 0) ? 1 : -1;
          total++; if (k != e) begin bad++; $display("FAIL rnd_pick got=%0d want=%0d", k, e); end
          if (mp[k] > 0) mp[k]--;
          act = k; dly = $urandom_range(0, 6); nrise++;
        end else if (!cur[k] && prev[k]) begin
          if (k == 1) minv1--;
          if (k == 2) minv2--;
          act = -1;
        end
      end
      mp[0] += dv; mp[1] += d1; mp[2] += d2 + 2 * d22;
      if (drs) begin minv1 = INV_INIT; minv2 = INV_INIT; end
      total++; if (inv1 !== 8'(minv1)) begin bad++; $display("FAIL rnd_inv1 got=%0d want=%0d", inv1, minv1); end
      total++; if (inv2 !== 8'(minv2)) begin bad++; $display("FAIL rnd_inv2 got=%0d want=%0d", inv2, minv2); end
      total++; if (fault !== 1'b0) begin bad++; $display("FAIL rnd_fault got=%b want=0", fault); end
      if (mp[0] + mp[1] + mp[2] > 0 || cur != 3'b000) begin
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL rnd_busy got=%b want=1", busy); end
      end
      dv = 0; d1 = 0; d2 = 0; d22 = 0; drs = 0;
      if (act >= 0) begin
        if (dly == 0) drive_ack(act);
        dly--;
      end
      if ($urandom_range(0, 7) == 0 && !cur[1]) hop1_ack = 1;
      if ($urandom_range(0, 7) == 0 && !cur[2]) hop2_ack = 1;
      if ($urandom_range(0, 7) == 0 && !cur[0]) motor_ack = 1;
      if (c < 1500) begin
        c1 = mp[1] + ((act == 1) ? 1 : 0);
        c2 = mp[2] + ((act == 2) ? 1 : 0);
        if ($urandom_range(0, 5) == 0 && mp[0] < 12) dv = 1;
        if ($urandom_range(0, 5) == 0 && mp[1] < 12 && c1 + 1 <= minv1) d1 = 1;
        r = $urandom_range(0, 7);
        if (r == 0 && mp[2] < 12 && c2 + 1 <= minv2) d2 = 1;
        else if (r == 1 && mp[2] < 11 && c2 + 2 <= minv2) d22 = 1;
        else if (r == 2 && mp[2] < 10 && c2 + 3 <= minv2) begin d2 = 1; d22 = 1; end
        if (cur == 3'b000 && (minv1 < 8 || minv2 < 8) && $urandom_range(0, 3) == 0) drs = 1;
      end
      vend = dv; out1 = d1; out2 = d2; out22 = d22; restock = drs;
      prev = cur;
      @(negedge clk);
    end
    clear_in();
    total++; if (mp[0] + mp[1] + mp[2] != 0) begin bad++; $display("FAIL rnd_drain got=%0d want=0", mp[0] + mp[1] + mp[2]); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rnd_idle got=%b want=0", busy); end
    total++; if (nrise < 20) begin bad++; $display("FAIL rnd_activity got=%0d want>=20", nrise); end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1; clear_in();
    repeat (2) @(negedge clk);
    test_reset();
    test_single_out2();
    test_order();
    test_timeout();
    test_drain();
    test_overflow();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
